// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one registered-read sprite ROM among N_REQ renderers, with optional grant lock.
// Latency: grant is combinational; rd_valid/rd_data arrive two cycles after the grant.
// Backpressure: none; requesters see gnt and retry by holding req, and one grant is issued every cycle with any req.
module sprite_rom_arbiter #(
  parameter int N_REQ      = 3,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            lock,
  input  logic [N_REQ*ADDR_WIDTH-1:0] addr,
  output logic [N_REQ-1:0]            gnt,
  output logic                        rom_en,
  output logic [ADDR_WIDTH-1:0]       rom_addr,
  input  logic [DATA_WIDTH-1:0]       rom_dout,
  output logic [N_REQ-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]       rd_data
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state, nxt_state;
  logic [PTR_W-1:0] ptr, nxt_ptr;
  logic [PTR_W-1:0] owner, nxt_owner;
  logic [N_REQ-1:0] v1;

  // search scratch
  logic [N_REQ-1:0] search_mask;
  logic             do_search;
  logic             found;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] idx_p;

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= nxt_state;
      ptr   <= nxt_ptr;
      owner <= nxt_owner;
    end
  end

  // Next-state and grant: held owner first, otherwise a rotating search starting at ptr.
  always_comb begin
    gnt         = '0;
    nxt_state   = state;
    nxt_ptr     = ptr;
    nxt_owner   = owner;
    search_mask = req;
    do_search   = 1'b0;
    found       = 1'b0;
    win         = '0;
    idx_p       = '0;

    if (!rst) begin
      case (state)
        ARB: begin
          do_search = 1'b1;
        end
        HOLD: begin
          if (req[owner]) begin
            // Owner keeps the port regardless of other requests; dropping lock makes this the last cycle.
            gnt[owner] = 1'b1;
            if (!lock[owner]) begin
              nxt_state = ARB;
            end
          end else begin
            // Owner released by dropping req: re-arbitrate among the others in this same cycle.
            do_search          = 1'b1;
            search_mask[owner] = 1'b0;
            nxt_state          = ARB;
          end
        end
        default: begin
          nxt_state = ARB;
        end
      endcase

      if (do_search) begin
        for (int k = 0; k < N_REQ; k++) begin
          int idx;
          idx = int'(ptr) + k;
          if (idx >= N_REQ) begin
            idx = idx - N_REQ;
          end
          idx_p = PTR_W'(idx);
          if (!found && search_mask[idx_p]) begin
            found = 1'b1;
            win   = idx_p;
          end
        end

        if (found) begin
          gnt[win]  = 1'b1;
          nxt_owner = win;
          nxt_ptr   = (win == PTR_W'(N_REQ - 1)) ? '0 : win + PTR_W'(1);
          nxt_state = lock[win] ? HOLD : ARB;
        end
      end
    end
  end

  // One-hot AND-OR address mux; zero when nothing is granted.
  always_comb begin
    rom_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rom_addr = rom_addr | ({ADDR_WIDTH{gnt[i]}} & addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end

  assign rom_en = |gnt;

  // Return pipeline: v1 tracks the ROM's registered read, stage 2 presents the word to its requester.
  // rd_data is zeroed when no read is returning, so a stale ROM output never shows up after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= '0;
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      v1       <= gnt;
      rd_valid <= v1;
      rd_data  <= (|v1) ? rom_dout : '0;
    end
  end

endmodule
